// File: rtl/key_event_arbiter_if.sv
// Event handshake between key_event_arbiter (master) and the command consumer (slave).
interface key_event_arbiter_if #(
    parameter int IDW = 2
) ();
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic           evt_ready;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/key_event_arbiter.sv
// Synchronises, debounces and edge-detects N request lines, then serialises the
// rising edges through a round-robin arbiter onto a valid/ready event stream.
module key_event_arbiter #(
    parameter int N        = 4,
    parameter int DEBOUNCE = 4,
    parameter int IDW      = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N-1:0]        req_async,
    input  logic                clr_ovf,
    key_event_arbiter_if.master evt,
    output logic [N-1:0]        pending,
    output logic                overflow
);
    localparam int             CW       = $clog2(DEBOUNCE) + 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE - 1);
    localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t         state;
    logic [N-1:0]   s1;
    logic [N-1:0]   s2;
    logic [N-1:0]   deb;
    logic [N-1:0]   deb_d;
    logic [N-1:0]   rise;
    logic [N-1:0]   grant;
    logic [CW-1:0]  cnt [N];
    logic [IDW-1:0] last;
    logic [IDW-1:0] sel;
    logic           found;
    int unsigned    idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= '0;
            s2    <= '0;
            deb_d <= '0;
        end else begin
            s1    <= req_async;
            s2    <= s1;
            deb_d <= deb;
        end
    end

    // A new level is adopted only after DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        rise = deb & ~deb_d;
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last) + k) % N;
            if (!found && pending[IDW'(idx)]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (state == IDLE && found) begin
            grant[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= (pending & ~grant) | rise;
            if ((rise & pending & ~grant) != '0) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            last          <= LAST_RST;
            evt.evt_valid <= 1'b0;
            evt.evt_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        evt.evt_id    <= sel;
                        evt.evt_valid <= 1'b1;
                        state         <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt.evt_ready) begin
                        last          <= evt.evt_id;
                        evt.evt_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
